// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: two-entry elastic pipeline stage (main + skid register)
// with valid/ready handshakes on both sides, an occupancy output and a
// saturating stall-cycle counter.
// Optional build macro PIPE_SKID_FLUSH_EN adds a FLUSH input that empties
// the stage without touching the stall counter.
module pipe_skid_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic             FLUSH,
`endif
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [1:0]       COUNT,
  output logic [CNT_W-1:0] STALL_CNT
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_flush;
  logic w_in_fire;
  logic w_out_fire;
  logic w_ld_main_in;
  logic w_ld_main_skid;
  logic w_ld_skid;

`ifdef PIPE_SKID_FLUSH_EN
  assign w_flush = FLUSH;
`else
  assign w_flush = 1'b0;
`endif

  // Ready depends only on state (plus reset/flush), never on OUT_READY,
  // so no combinational path runs from the consumer back to the producer.
  assign IN_READY   = ~RST & ~w_flush & (r_state != ST_TWO);
  assign OUT_VALID  = (r_state != ST_EMPTY);
  assign OUT_DATA   = r_main;
  assign COUNT      = r_state;
  assign STALL_CNT  = r_stall_cnt;

  assign w_in_fire  = IN_VALID & IN_READY;
  assign w_out_fire = OUT_VALID & OUT_READY;

  // State register; reset discards everything in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and register load selection from the two handshakes.
  always_comb begin
    w_state_next   = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (w_flush) begin
      // Contents are abandoned in place; only the occupancy is cleared.
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_ld_main_in = 1'b1;
            w_state_next = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_ld_main_in = 1'b1;
          end else if (w_in_fire) begin
            w_ld_skid    = 1'b1;
            w_state_next = ST_TWO;
          end else if (w_out_fire) begin
            w_state_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_out_fire) begin
            w_ld_main_skid = 1'b1;
            w_state_next   = ST_ONE;
          end
        end
        default: begin
          w_state_next = ST_EMPTY;
        end
      endcase
    end
  end

  // Data registers: main is the head of the queue, skid holds the second word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main <= IN_DATA;
      end else if (w_ld_main_skid) begin
        r_main <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= IN_DATA;
      end
    end
  end

  // Stall counter: counts edges where a word is offered but not taken,
  // saturating at all-ones; a flush cycle leaves it untouched.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt <= '0;
    end else if (!w_flush && OUT_VALID && !OUT_READY && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Testbench for pipe_skid_buf: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_pipe_skid_buf;

  localparam int WIDTH = 32;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [1:0]        count;
  logic [15:0]       stall_cnt;

  // Second instance with a narrow counter, driven identically, to see saturation.
  logic              n_in_ready;
  logic              n_out_valid;
  logic [WIDTH-1:0]  n_out_data;
  logic [1:0]        n_count;
  logic [3:0]        n_stall_cnt;

  int errs;
  int checks;

  // Reference model state
  logic [WIDTH-1:0] mq[$];
  int               m_stall16;
  int               m_stall4;

  pipe_skid_buf #(.WIDTH(WIDTH), .CNT_W(16)) u_dut (
    .CLK       (clk),
    .RST       (rst),
`ifdef PIPE_SKID_FLUSH_EN
    .FLUSH     (flush),
`endif
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN_DATA   (in_data),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT_DATA  (out_data),
    .COUNT     (count),
    .STALL_CNT (stall_cnt)
  );

  pipe_skid_buf #(.WIDTH(WIDTH), .CNT_W(4)) u_dut_n (
    .CLK       (clk),
    .RST       (rst),
`ifdef PIPE_SKID_FLUSH_EN
    .FLUSH     (flush),
`endif
    .IN_VALID  (in_valid),
    .IN_READY  (n_in_ready),
    .IN_DATA   (in_data),
    .OUT_VALID (n_out_valid),
    .OUT_READY (out_ready),
    .OUT_DATA  (n_out_data),
    .COUNT     (n_count),
    .STALL_CNT (n_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, compare outputs mid-cycle, advance model at the edge.
  task automatic step(input logic r, input logic iv, input logic [WIDTH-1:0] d,
                      input logic ordy, input logic fl);
    logic exp_ready;
    logic exp_valid;
    logic in_fire;
    logic out_fire;
    rst       = r;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
`ifdef PIPE_SKID_FLUSH_EN
    flush     = fl;
`else
    flush     = 1'b0;
`endif
    #4;
    exp_ready = !rst && !flush && (mq.size() < 2);
    exp_valid = (mq.size() > 0);
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
    chk("count", {62'd0, count}, 64'(mq.size()));
    chk("stall_cnt", {48'd0, stall_cnt}, 64'(m_stall16));
    chk("stall_cnt_n", {60'd0, n_stall_cnt}, 64'(m_stall4));
    if (exp_valid) chk("out_data", {32'd0, out_data}, {32'd0, mq[0]});
    $display("cyc t=%0t rst=%0b fl=%0b iv=%0b d=%0h rdy=%0b ov=%0b od=%0h ordy=%0b cnt=%0d stall=%0d",
             $time, rst, flush, in_valid, in_data, in_ready, out_valid, out_data,
             out_ready, count, stall_cnt);
    in_fire  = iv && exp_ready;
    out_fire = exp_valid && ordy;
    if (rst) begin
      mq.delete();
      m_stall16 = 0;
      m_stall4  = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (exp_valid && !ordy) begin
        if (m_stall16 < 65535) m_stall16++;
        if (m_stall4 < 15) m_stall4++;
      end
      if (out_fire) void'(mq.pop_front());
      if (in_fire) mq.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic fl_r;
    errs      = 0;
    checks    = 0;
    m_stall16 = 0;
    m_stall4  = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;

    // Reset then pass-through
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) step(0, 1, 32'hA5A5_0000 + i, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Backpressure fill then release
    step(0, 1, 32'h11, 0, 0);
    step(0, 1, 32'h22, 0, 0);
    step(0, 1, 32'h33, 0, 0);
    step(0, 1, 32'h33, 1, 0);
    step(0, 1, 32'h33, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Simultaneous in/out while holding one word
    step(0, 1, 32'h10, 0, 0);
    step(0, 1, 32'h20, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);

    // Stall counter saturation on the narrow instance
    step(0, 1, 32'h5A, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);

    // Reset mid-operation while full
    step(0, 1, 32'hAA, 0, 0);
    step(0, 1, 32'hBB, 0, 0);
    step(1, 1, 32'hEE, 1, 0);
    step(0, 1, 32'hCC, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

`ifdef PIPE_SKID_FLUSH_EN
    // Flush while full, with a word offered in the same cycle
    step(0, 1, 32'h01, 0, 0);
    step(0, 1, 32'h02, 0, 0);
    step(0, 1, 32'hDD, 0, 1);
    step(0, 0, 0, 1, 0);
    step(0, 1, 32'h03, 1, 0);
    step(0, 0, 0, 1, 0);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      fl_r = ($urandom_range(0, 15) == 0);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), $urandom,
           ($urandom_range(0, 9) < 6), fl_r);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
